cond_exec_unit: RTL

Execute-stage conditional-execution unit for the pipelined ARM core. It sits directly downstream of the ALU. It owns the architectural NZCV flag register, updated from `ALUFlags` under `FlagW` control. It evaluates the 4-bit condition field of the instruction in Execute against the stored flags, gates that instruction's write enables, and registers the gated controls into the Memory stage. Two squash/execute statistics counters for the bench and debug are included.

---
 rtl/arm_pkg.sv | 26 ++
 rtl/cond_check.sv | 41 ++++
 rtl/cond_exec_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARM core definitions: condition codes and NZCV flag bit positions.
package arm_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against NZCV flags.
module cond_check
   import arm_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   // Decode the condition field; NV never executes.
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = (n == v);
         COND_LT: CondEx = (n != v);
         COND_GT: CondEx = ~z & (n == v);
         COND_LE: CondEx = z | (n != v);
         COND_AL: CondEx = 1'b1;
         COND_NV: CondEx = 1'b0;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage conditional execution: NZCV register, write-enable gating,
// E->M control register and exec/skip statistics counters.
module cond_exec_unit
   import arm_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ValidE,
   input  logic             AdvanceE,
   input  logic [3:0]       CondE,
   input  logic [1:0]       FlagWE,
   input  logic             PCSE,
   input  logic             RegWE,
   input  logic             MemWE,
   input  logic             NoWriteE,
   input  logic [3:0]       ALUFlags,
   output logic             CondExE,
   output logic [3:0]       Flags,
   output logic             PCSrcM,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SkipCount
);

   logic fire;
   logic retire;

   cond_check u_cond_check (
      .Cond   (CondE),
      .Flags  (Flags),
      .CondEx (CondExE)
   );

   assign retire = ValidE & AdvanceE;
   assign fire   = retire & CondExE;

   // Architectural flags; N,Z and C,V groups written independently.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         Flags <= 4'b0000;
      end else if (fire) begin
         if (FlagWE[1]) begin
            Flags[FLAG_N] <= ALUFlags[FLAG_N];
            Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (FlagWE[0]) begin
            Flags[FLAG_C] <= ALUFlags[FLAG_C];
            Flags[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   // M-stage controls; a stall pushes a bubble into M.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         PCSrcM    <= 1'b0;
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (AdvanceE) begin
         PCSrcM    <= fire & PCSE;
         RegWriteM <= fire & RegWE & ~NoWriteE;
         MemWriteM <= fire & MemWE;
      end else begin
         PCSrcM    <= 1'b0;
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
      end
   end

   // Retirement statistics, wrapping counters.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ExecCount <= '0;
         SkipCount <= '0;
      end else if (retire) begin
         if (CondExE) ExecCount <= ExecCount + CNT_W'(1);
         else         SkipCount <= SkipCount + CNT_W'(1);
      end
   end

endmodule
